// File: rtl/freq_meas_pkg.sv
// Shared definitions for the frequency measurement block and its tick generator.
//   state_t      : measurement FSM encoding (IDLE = no reference edge, MEAS = counting)
//   DEF_*        : default tick spacing / tolerance / lock depth / timeout constants
package freq_meas_pkg;

   localparam int unsigned CNT_W = 32;

   typedef enum logic {
      IDLE = 1'b0,
      MEAS = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] DEF_FREQ     = 32'd10000;
   localparam logic [CNT_W-1:0] DEF_TOL      = 32'd2;
   localparam logic [CNT_W-1:0] DEF_TIMEOUT  = 32'd40000;
   localparam int unsigned      DEF_LOCK_CNT = 4;

endpackage

// File: rtl/freq_tol_cmp.sv
// Combinational tolerance window test for a captured period.
//   cnt     : captured edge-to-edge spacing in valid cycles
//   match_c : 1 when FREQ+1-TOL <= cnt <= FREQ+1+TOL (lower bound clamped at 0)
module freq_tol_cmp
   import freq_meas_pkg::*;
#(
   parameter logic [CNT_W-1:0] FREQ = DEF_FREQ,
   parameter logic [CNT_W-1:0] TOL  = DEF_TOL
) (
   input  logic [CNT_W-1:0] cnt,
   output logic             match_c
);

   localparam int unsigned WW = CNT_W + 1;

   // Widened by one bit so FREQ+1+TOL cannot wrap.
   localparam logic [WW-1:0] TARGET = WW'(FREQ) + WW'(1);
   localparam logic [WW-1:0] TOL_W  = WW'(TOL);
   localparam logic [WW-1:0] LO     = (TARGET >= TOL_W) ? (TARGET - TOL_W) : '0;
   localparam logic [WW-1:0] HI     = TARGET + TOL_W;

   logic [WW-1:0] cnt_w;

   assign cnt_w   = WW'(cnt);
   assign match_c = (cnt_w >= LO) && (cnt_w <= HI);

endmodule

// File: rtl/freq_meas.sv
// Measures the spacing between rising edges of a clk-synchronous tick stream,
// counting only cycles where valid is high, and declares lock after LOCK_CNT
// consecutive in-tolerance periods.
//   clk          : single clock, rising edge
//   rst          : synchronous, active-low reset
//   valid        : count / edge-detect enable
//   pulse_in     : tick stream (already synchronous to clk)
//   period       : last captured edge-to-edge spacing in valid cycles
//   period_valid : one-cycle strobe when period updates
//   locked       : last LOCK_CNT periods were all within tolerance
//   timeout      : one-cycle strobe when no edge arrived for TIMEOUT valid cycles
module freq_meas
   import freq_meas_pkg::*;
#(
   parameter logic [CNT_W-1:0] FREQ     = DEF_FREQ,
   parameter logic [CNT_W-1:0] TOL      = DEF_TOL,
   parameter int unsigned      LOCK_CNT = DEF_LOCK_CNT,
   parameter logic [CNT_W-1:0] TIMEOUT  = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             locked,
   output logic             timeout
);

   localparam int unsigned MW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
   localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_CNT);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [MW-1:0]    match_cnt, match_nxt;
   logic [CNT_W-1:0] period_nxt;
   logic             period_valid_nxt, locked_nxt, timeout_nxt;
   logic             pulse_d;
   logic             rise_c;
   logic             match_c;

   // Rising edge of the tick, qualified by valid; pulse_d tracks every cycle.
   assign rise_c = valid & pulse_in & ~pulse_d;

   freq_tol_cmp #(
      .FREQ (FREQ),
      .TOL  (TOL)
   ) u_cmp (
      .cnt     (cnt),
      .match_c (match_c)
   );

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= '0;
         match_cnt    <= '0;
         pulse_d      <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         match_cnt    <= match_nxt;
         pulse_d      <= pulse_in;
         period       <= period_nxt;
         period_valid <= period_valid_nxt;
         locked       <= locked_nxt;
         timeout      <= timeout_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt        = state;
      cnt_nxt          = cnt;
      match_nxt        = match_cnt;
      period_nxt       = period;
      period_valid_nxt = 1'b0;
      locked_nxt       = locked;
      timeout_nxt      = 1'b0;

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            // First edge only establishes the reference point.
            if (rise_c) begin
               state_nxt = MEAS;
               cnt_nxt   = CNT_W'(1);
            end
         end
         MEAS: begin
            // An edge takes priority over a coincident timeout.
            if (rise_c) begin
               period_nxt       = cnt;
               period_valid_nxt = 1'b1;
               cnt_nxt          = CNT_W'(1);
               if (!match_c) begin
                  match_nxt = '0;
               end else if (match_cnt != LOCK_MAX) begin
                  match_nxt = match_cnt + MW'(1);
               end
               locked_nxt = (match_nxt == LOCK_MAX);
            end else if (valid) begin
               if (cnt == TIMEOUT) begin
                  timeout_nxt = 1'b1;
                  state_nxt   = IDLE;
                  cnt_nxt     = '0;
                  match_nxt   = '0;
                  locked_nxt  = 1'b0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_freq_meas.sv
// Randomised scoreboard bench for freq_meas with FREQ=10, TOL=2, LOCK_CNT=4, TIMEOUT=30.
module tb_freq_meas;

   localparam int unsigned FREQ     = 10;
   localparam int unsigned TOL      = 2;
   localparam int unsigned LOCK_CNT = 4;
   localparam int unsigned TIMEOUT  = 30;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid = 1'b0;
   logic        pulse_in = 1'b0;
   logic [31:0] period;
   logic        period_valid;
   logic        locked;
   logic        timeout;

   freq_meas #(
      .FREQ     (32'(FREQ)),
      .TOL      (32'(TOL)),
      .LOCK_CNT (LOCK_CNT),
      .TIMEOUT  (32'(TIMEOUT))
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .valid        (valid),
      .pulse_in     (pulse_in),
      .period       (period),
      .period_valid (period_valid),
      .locked       (locked),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_to;
      int unsigned per;
      bit          lk;
      int unsigned cyc;
   } exp_t;

   exp_t        sb[$];
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;
   bit          mon_en = 0;

   // Reference model: valid cycles elapsed since the last accepted edge,
   // plus a sliding window of the most recent in-tolerance verdicts.
   bit          m_armed = 0;
   int unsigned m_elapsed = 0;
   int unsigned m_period = 0;
   bit          m_locked = 0;
   bit          m_prev = 0;
   bit          hist[$];

   always @(posedge clk) begin
      bit   rise;
      bit   ok;
      exp_t e;
      cyc++;
      rise   = valid && pulse_in && !m_prev;
      m_prev = rst ? pulse_in : 1'b0;
      if (!rst) begin
         m_armed = 0; m_elapsed = 0; m_period = 0; m_locked = 0;
         hist.delete();
      end else if (rise) begin
         if (m_armed) begin
            ok = (m_elapsed + TOL >= FREQ + 1) && (m_elapsed <= FREQ + 1 + TOL);
            hist.push_back(ok);
            if (hist.size() > LOCK_CNT) void'(hist.pop_front());
            m_locked = (hist.size() == LOCK_CNT);
            foreach (hist[i]) if (!hist[i]) m_locked = 0;
            m_period = m_elapsed;
            e.is_to = 0; e.per = m_elapsed; e.lk = m_locked; e.cyc = cyc;
            sb.push_back(e);
         end
         m_armed   = 1;
         m_elapsed = 1;
      end else if (valid && m_armed) begin
         if (m_elapsed == TIMEOUT) begin
            e.is_to = 1; e.per = m_period; e.lk = 0; e.cyc = cyc;
            sb.push_back(e);
            m_armed = 0; m_elapsed = 0; m_locked = 0;
            hist.delete();
         end else begin
            m_elapsed++;
         end
      end
   end

   // Monitor: compares level outputs every cycle and pops the scoreboard on strobes.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         checks++;
         if (period !== 32'(m_period)) begin
            errors++;
            $display("FAIL period_level cyc=%0d got=%0d exp=%0d", cyc, period, m_period);
         end
         checks++;
         if (locked !== m_locked) begin
            errors++;
            $display("FAIL locked_level cyc=%0d got=%0b exp=%0b", cyc, locked, m_locked);
         end
         if (period_valid !== 1'b0 || timeout !== 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_strobe cyc=%0d period_valid=%0b timeout=%0b", cyc, period_valid, timeout);
            end else begin
               e = sb.pop_front();
               if (e.cyc != cyc || timeout !== e.is_to || period_valid !== !e.is_to ||
                   period !== 32'(e.per) || locked !== e.lk) begin
                  errors++;
                  $display("FAIL strobe cyc=%0d got pv=%0b to=%0b per=%0d lk=%0b exp cyc=%0d to=%0b per=%0d lk=%0b",
                           cyc, period_valid, timeout, period, locked, e.cyc, e.is_to, e.per, e.lk);
               end
            end
         end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            checks++;
            errors++;
            e = sb.pop_front();
            $display("FAIL missing_strobe cyc=%0d exp to=%0b per=%0d", cyc, e.is_to, e.per);
         end
      end
   end

   task automatic drive(input bit p, input bit v, input bit r);
      @(negedge clk);
      pulse_in = p;
      valid    = v;
      rst      = r;
   endtask

   task automatic pulse(input int width);
      for (int i = 0; i < width; i++) drive(1'b1, 1'b1, 1'b1);
   endtask

   task automatic idle(input int n, input bit v);
      for (int i = 0; i < n; i++) drive(1'b0, v, 1'b1);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);
      @(posedge clk);
      mon_en = 1;

      // Nominal 11-cycle ticks: lock on the 5th edge.
      for (int k = 0; k < 6; k++) begin pulse(1); idle(10, 1'b1); end
      // One 14-cycle gap breaks lock, then relock.
      pulse(1); idle(13, 1'b1);
      for (int k = 0; k < 5; k++) begin pulse(1); idle(10, 1'b1); end
      // Timeout 30 valid cycles after the last edge; next pulse only re-arms.
      pulse(1); idle(35, 1'b1);
      pulse(1); idle(10, 1'b1); pulse(1); idle(10, 1'b1);
      // valid low for 5 clocks inside an 11-valid-cycle spacing, with an ignored pulse.
      pulse(1); idle(5, 1'b1);
      drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1); drive(1'b0, 1'b0, 1'b1); drive(1'b0, 1'b0, 1'b1);
      idle(5, 1'b1);
      // Held-high pulse yields one edge.
      pulse(3); idle(8, 1'b1); pulse(1); idle(10, 1'b1);
      // Edge coincident with the timeout count: capture wins.
      pulse(1); idle(29, 1'b1); pulse(1); idle(10, 1'b1);
      // Reset mid-measurement; first edge after release re-arms only.
      pulse(1); idle(5, 1'b1); drive(1'b0, 1'b1, 1'b0);
      idle(3, 1'b1); pulse(1); idle(10, 1'b1); pulse(1); idle(10, 1'b1);

      // Random ticks around the nominal spacing with valid dropouts and resets.
      for (int k = 0; k < 300; k++) begin
         int w, sp, vp;
         w  = int'($urandom_range(3, 1));
         sp = int'($urandom_range(36, 8));
         vp = ($urandom_range(3, 0) == 0) ? int'($urandom_range(95, 60)) : 100;
         for (int c = 0; c < sp; c++) begin
            bit v, r;
            v = (vp >= 100) ? 1'b1 : ($urandom_range(99, 0) < 32'(vp));
            r = ($urandom_range(999, 0) < 5) ? 1'b0 : 1'b1;
            drive(c < w, v, r);
         end
      end

      idle(40, 1'b1);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
